// File: rtl/bus_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr_if
// Purpose  : Request/grant bundle between two bus masters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_rr_if #(
  parameter int unsigned CNT_W = 8
);
  logic             M0_req;
  logic             M1_req;
  logic             M0_grant;
  logic             M1_grant;
  logic [1:0]       arb_state;
  logic [CNT_W-1:0] burst_cnt;

  // Requesters drive requests and observe grants.
  modport master (
    output M0_req,
    output M1_req,
    input  M0_grant,
    input  M1_grant,
    input  arb_state,
    input  burst_cnt
  );

  // The arbiter consumes requests and produces grants and status.
  modport slave (
    input  M0_req,
    input  M1_req,
    output M0_grant,
    output M1_grant,
    output arb_state,
    output burst_cnt
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr
// Purpose  : Two-master round-robin arbiter, registered grants, burst counter.
//            Define ARB_BURST_LIMIT_EN to force a handoff after BURST_MAX
//            cycles when the other master is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  bus_arbiter_rr_if.slave bus_if
);

  localparam logic [1:0]       c_S_IDLE  = 2'b00;
  localparam logic [1:0]       c_S_GNT0  = 2'b01;
  localparam logic [1:0]       c_S_GNT1  = 2'b10;
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(BURST_MAX - 1);

`ifdef ARB_BURST_LIMIT_EN
  localparam logic c_LIMIT_EN = 1'b1;
`else
  localparam logic c_LIMIT_EN = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_m0_req;
  logic             w_m1_req;
  logic             w_at_max;
  logic             w_force0;
  logic             w_force1;

  assign w_m0_req = bus_if.M0_req;
  assign w_m1_req = bus_if.M1_req;
  assign w_at_max = (cnt_q == c_CNT_MAX);

  // Expiry only yields the bus when the owner still wants it and the peer waits.
  assign w_force0 = c_LIMIT_EN & w_at_max & w_m0_req & w_m1_req;
  assign w_force1 = c_LIMIT_EN & w_at_max & w_m1_req & w_m0_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE: begin
        if (w_m0_req && w_m1_req) begin
          state_d = last_q ? c_S_GNT0 : c_S_GNT1;
        end else if (w_m0_req) begin
          state_d = c_S_GNT0;
        end else if (w_m1_req) begin
          state_d = c_S_GNT1;
        end else begin
          state_d = c_S_IDLE;
        end
      end
      c_S_GNT0: begin
        if (!w_m0_req) begin
          state_d = w_m1_req ? c_S_GNT1 : c_S_IDLE;
        end else if (w_force0) begin
          state_d = c_S_GNT1;
        end else begin
          state_d = c_S_GNT0;
        end
      end
      c_S_GNT1: begin
        if (!w_m1_req) begin
          state_d = w_m0_req ? c_S_GNT0 : c_S_IDLE;
        end else if (w_force1) begin
          state_d = c_S_GNT0;
        end else begin
          state_d = c_S_GNT1;
        end
      end
      default: state_d = c_S_IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    cnt_d  = '0;
    if (state_d == c_S_GNT0) begin
      last_d = 1'b0;
    end else if (state_d == c_S_GNT1) begin
      last_d = 1'b1;
    end
    // Count only while the same owner keeps the bus; saturate rather than wrap.
    if ((state_d != c_S_IDLE) && (state_d == state_q)) begin
      cnt_d = w_at_max ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus_if.M0_grant  = (state_q == c_S_GNT0);
    bus_if.M1_grant  = (state_q == c_S_GNT1);
    bus_if.arb_state = state_q;
    bus_if.burst_cnt = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus_if.M0_grant && bus_if.M1_grant));
      assert (state_q != 2'b11);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_rr
// Purpose  : Directed self-checking bench for bus_arbiter_rr (BURST_MAX=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

  localparam int unsigned c_CNT_W = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bus_arbiter_rr_if #(.CNT_W(c_CNT_W)) bus_if ();

  bus_arbiter_rr #(
    .BURST_MAX (4),
    .CNT_W     (c_CNT_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot", 32'(bus_if.M0_grant & bus_if.M1_grant), 32'd0);
  endtask

  task automatic expect_bus(input string tag, input logic g0, input logic g1,
                            input logic [1:0] st, input int cnt);
    chk({tag, ".g0"},  32'(bus_if.M0_grant),  32'(g0));
    chk({tag, ".g1"},  32'(bus_if.M1_grant),  32'(g1));
    chk({tag, ".st"},  32'(bus_if.arb_state), 32'(st));
    chk({tag, ".cnt"}, 32'(bus_if.burst_cnt), 32'(cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus_if.M0_req = 1'b1;
    bus_if.M1_req = 1'b1;

    // Reset held with both requesting.
    step();
    step();
    expect_bus("rst", 1'b0, 1'b0, 2'b00, 0);
    reset = 1'b0;
    step();
    expect_bus("rst_rel", 1'b1, 1'b0, 2'b01, 0);

    // Tie rotation with single-cycle request drops.
    step();
    expect_bus("rot0_c1", 1'b1, 1'b0, 2'b01, 1);
    step();
    expect_bus("rot0_c2", 1'b1, 1'b0, 2'b01, 2);
    bus_if.M0_req = 1'b0;
    step();
    expect_bus("rot_h1", 1'b0, 1'b1, 2'b10, 0);
    bus_if.M0_req = 1'b1;
    step();
    step();
    expect_bus("rot1_c2", 1'b0, 1'b1, 2'b10, 2);
    bus_if.M1_req = 1'b0;
    step();
    expect_bus("rot_h2", 1'b1, 1'b0, 2'b01, 0);
    bus_if.M1_req = 1'b1;

    // Release both, then a tie from IDLE must go to M1 (M0 was last).
    bus_if.M0_req = 1'b0;
    bus_if.M1_req = 1'b0;
    step();
    expect_bus("idle1", 1'b0, 1'b0, 2'b00, 0);
    bus_if.M0_req = 1'b1;
    bus_if.M1_req = 1'b1;
    step();
    expect_bus("tie_last0", 1'b0, 1'b1, 2'b10, 0);
    bus_if.M0_req = 1'b0;
    bus_if.M1_req = 1'b0;
    step();
    expect_bus("idle2", 1'b0, 1'b0, 2'b00, 0);

    // Single-cycle M1 request.
    bus_if.M1_req = 1'b1;
    step();
    expect_bus("m1_pulse", 1'b0, 1'b1, 2'b10, 0);
    bus_if.M1_req = 1'b0;
    step();
    expect_bus("m1_drop", 1'b0, 1'b0, 2'b00, 0);

    // Burst: M0 holds, M1 joins from the second grant cycle.
    bus_if.M0_req = 1'b1;
    step();
    expect_bus("bst_c0", 1'b1, 1'b0, 2'b01, 0);
    bus_if.M1_req = 1'b1;
    step();
    expect_bus("bst_c1", 1'b1, 1'b0, 2'b01, 1);
    step();
    expect_bus("bst_c2", 1'b1, 1'b0, 2'b01, 2);
    step();
    expect_bus("bst_c3", 1'b1, 1'b0, 2'b01, 3);
    step();
`ifdef ARB_BURST_LIMIT_EN
    expect_bus("bst_hand", 1'b0, 1'b1, 2'b10, 0);
    step();
    step();
    step();
    expect_bus("bst1_c3", 1'b0, 1'b1, 2'b10, 3);
    step();
    expect_bus("bst_back", 1'b1, 1'b0, 2'b01, 0);
    bus_if.M0_req = 1'b0;
    step();
    expect_bus("bst_rel", 1'b0, 1'b1, 2'b10, 0);
`else
    expect_bus("nolim_c4", 1'b1, 1'b0, 2'b01, 3);
    for (int i = 0; i < 20; i++) begin
      step();
    end
    expect_bus("nolim_c24", 1'b1, 1'b0, 2'b01, 3);
    bus_if.M0_req = 1'b0;
    step();
    expect_bus("nolim_rel", 1'b0, 1'b1, 2'b10, 0);
`endif

    // Reset in the middle of an M1 burst.
    bus_if.M0_req = 1'b1;
    step();
    step();
    expect_bus("mid_c2", 1'b0, 1'b1, 2'b10, 2);
    reset = 1'b1;
    step();
    expect_bus("mid_rst", 1'b0, 1'b0, 2'b00, 0);
    reset = 1'b0;
    step();
    expect_bus("mid_rel", 1'b1, 1'b0, 2'b01, 0);

    // Lone owner saturates the counter and keeps the bus.
    bus_if.M1_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
    end
    expect_bus("sat", 1'b1, 1'b0, 2'b01, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
